// File: rtl/bbox_scan_unit.sv
// Scans N_VERT signed fixed-point vertices into screen-clamped integer pixel bounds.
// Define BBOX_TILE_ALIGN_EN to widen non-empty bounds outward to 2^TILE_LOG2 tile edges.
module bbox_scan_unit #(
  parameter int N_VERT    = 3,
  parameter int COORD_W   = 16,
  parameter int FRAC_W    = 4,
  parameter int SCREEN_W  = 256,
  parameter int SCREEN_H  = 256,
  parameter int TILE_LOG2 = 3,
  localparam int IDX_W = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_VERT*2*COORD_W-1:0] in_vertices,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            x_min,
  output logic [IDX_W-1:0]            x_max,
  output logic [IDX_W-1:0]            y_min,
  output logic [IDX_W-1:0]            y_max,
  output logic                        out_empty,
  output logic                        busy
);

  localparam int VW    = N_VERT * 2 * COORD_W;
  localparam int CNT_W = $clog2(N_VERT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VERT - 1);
  localparam logic signed [COORD_W-1:0] POS_MAX = {1'b0, {(COORD_W-1){1'b1}}};
  localparam logic signed [COORD_W-1:0] NEG_MAX = {1'b1, {(COORD_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, CLAMP, DONE} state_t;

  state_t                     state_q;
  logic [VW-1:0]              vert_q;
  logic [CNT_W-1:0]           cnt_q;
  logic signed [COORD_W-1:0]  xMin_q, xMax_q, yMin_q, yMax_q;
  logic [IDX_W-1:0]           xLo_q, xHi_q, yLo_q, yHi_q;
  logic                       empty_q, outValid_q, inReady_q, busy_q;

  logic signed [COORD_W-1:0]  curX, curY;
  logic signed [COORD_W-1:0]  ixMinS, ixMaxS, iyMinS, iyMaxS;
  logic [IDX_W-1:0]           xLo_d, xHi_d, yLo_d, yHi_d;
  logic                       empty_d;
  int                         ixMin, ixMax, iyMin, iyMax;
  int                         cxMin, cxMax, cyMin, cyMax;

  // The vertex register shifts left each SCAN cycle, so the current vertex is always in the MSBs.
  assign curX = vert_q[VW-1 -: COORD_W];
  assign curY = vert_q[VW-COORD_W-1 -: COORD_W];

  function automatic int clampInt(input int v, input int hi);
    if (v < 0)       return 0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

`ifdef BBOX_TILE_ALIGN_EN
  localparam int TILE_MASK = (1 << TILE_LOG2) - 1;
`else
  logic unusedTile;
  assign unusedTile = (TILE_LOG2 != 0);
`endif

  // Arithmetic shift floors every bound, so negative fractions round toward -inf.
  always_comb begin
    ixMinS = xMin_q >>> FRAC_W;
    ixMaxS = xMax_q >>> FRAC_W;
    iyMinS = yMin_q >>> FRAC_W;
    iyMaxS = yMax_q >>> FRAC_W;
    ixMin  = int'(ixMinS);
    ixMax  = int'(ixMaxS);
    iyMin  = int'(iyMinS);
    iyMax  = int'(iyMaxS);
    empty_d = (ixMax < 0) || (ixMin > SCREEN_W - 1) ||
              (iyMax < 0) || (iyMin > SCREEN_H - 1);
    cxMin = clampInt(ixMin, SCREEN_W - 1);
    cxMax = clampInt(ixMax, SCREEN_W - 1);
    cyMin = clampInt(iyMin, SCREEN_H - 1);
    cyMax = clampInt(iyMax, SCREEN_H - 1);
`ifdef BBOX_TILE_ALIGN_EN
    cxMin = cxMin & ~TILE_MASK;
    cyMin = cyMin & ~TILE_MASK;
    cxMax = clampInt(cxMax | TILE_MASK, SCREEN_W - 1);
    cyMax = clampInt(cyMax | TILE_MASK, SCREEN_H - 1);
`endif
    if (empty_d) begin
      cxMin = 0;
      cxMax = 0;
      cyMin = 0;
      cyMax = 0;
    end
    xLo_d = IDX_W'(cxMin);
    xHi_d = IDX_W'(cxMax);
    yLo_d = IDX_W'(cyMin);
    yHi_d = IDX_W'(cyMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vert_q     <= '0;
      cnt_q      <= '0;
      xMin_q     <= '0;
      xMax_q     <= '0;
      yMin_q     <= '0;
      yMax_q     <= '0;
      xLo_q      <= '0;
      xHi_q      <= '0;
      yLo_q      <= '0;
      yHi_q      <= '0;
      empty_q    <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vert_q    <= in_vertices;
            xMin_q    <= POS_MAX;
            yMin_q    <= POS_MAX;
            xMax_q    <= NEG_MAX;
            yMax_q    <= NEG_MAX;
            cnt_q     <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (curX < xMin_q) xMin_q <= curX;
          if (curX > xMax_q) xMax_q <= curX;
          if (curY < yMin_q) yMin_q <= curY;
          if (curY > yMax_q) yMax_q <= curY;
          vert_q <= vert_q << (2 * COORD_W);
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_q <= CLAMP;
        end
        CLAMP: begin
          xLo_q      <= xLo_d;
          xHi_q      <= xHi_d;
          yLo_q      <= yLo_d;
          yHi_q      <= yHi_d;
          empty_q    <= empty_d;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign out_empty = empty_q;
  assign x_min     = xLo_q;
  assign x_max     = xHi_q;
  assign y_min     = yLo_q;
  assign y_max     = yHi_q;

endmodule
